regfile_write_arbiter: RTL and testbench

Shares the register file's single write path between three result producers: ALU, multiply/divide unit and load unit. Requesters are arbitrated round-robin, and the grant drives the register file's write controls from registered outputs. A 16-bit busy scoreboard tracks registers with an outstanding write, so decode can stall on read-after-write hazards. The block sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// busy scoreboard so decode can stall on registers that have a write pending.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              req_valid,
    output logic [2:0]              req_ready,
    input  logic [2:0]              req_dest_en,
    input  logic [2:0]              req_r0_en,
    input  logic [3*ADDR_WIDTH-1:0] req_dest,
    input  logic [3*DATA_WIDTH-1:0] req_data,
    input  logic [3*DATA_WIDTH-1:0] req_r0data,
    input  logic                    claim_valid,
    input  logic                    claim_dest_en,
    input  logic [ADDR_WIDTH-1:0]   claim_dest,
    input  logic                    claim_r0_en,
    output logic [1:0]              registerWrite,
    output logic [ADDR_WIDTH-1:0]   regWriteLocal,
    output logic [DATA_WIDTH-1:0]   dataWrite,
    output logic [DATA_WIDTH-1:0]   r0Write,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic [1:0]            lastGrant_q, lastGrant_d;
    logic [1:0]            registerWrite_q, registerWrite_d;
    logic [ADDR_WIDTH-1:0] regWriteLocal_q;
    logic [DATA_WIDTH-1:0] dataWrite_q;
    logic [DATA_WIDTH-1:0] r0Write_q;
    logic [NREGS-1:0]      busy_q, busy_d;

    logic [2:0]            grant;
    logic                  found;
    int                    selIdx;
    logic                  transfer;
    logic                  selDestEn, selR0En;
    logic [ADDR_WIDTH-1:0] selDest;
    logic [NREGS-1:0]      setMask, clrMask;

    // Search begins just after the last granted requester and wraps over three slots.
    always_comb begin
        int start;
        int idx;
        grant  = 3'b000;
        found  = 1'b0;
        selIdx = 0;
        start  = (lastGrant_q == 2'd2) ? 0 : int'(lastGrant_q) + 1;
        for (int k = 0; k < 3; k++) begin
            idx = start + k;
            if (idx >= 3) begin
                idx = idx - 3;
            end
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                selIdx     = idx;
            end
        end
    end

    assign req_ready = reset ? 3'b000 : grant;
    assign transfer  = found && !reset;

    assign selDestEn = req_dest_en[selIdx];
    assign selR0En   = req_r0_en[selIdx];
    assign selDest   = req_dest[selIdx*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
        registerWrite_d = 2'b00;
        lastGrant_d     = lastGrant_q;
        if (transfer) begin
            // A dest write to R0 collides with the secondary R0 write; the dest data wins.
            registerWrite_d = {selR0En && !(selDestEn && selDest == '0), selDestEn};
            lastGrant_d     = 2'(selIdx);
        end
    end

    // Claims set bits; the write currently on the output register clears them, claims win ties.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (claim_valid && claim_dest_en) begin
            setMask[claim_dest] = 1'b1;
        end
        if (claim_valid && claim_r0_en) begin
            setMask[0] = 1'b1;
        end
        if (registerWrite_q[0]) begin
            clrMask[regWriteLocal_q] = 1'b1;
        end
        if (registerWrite_q[1]) begin
            clrMask[0] = 1'b1;
        end
        busy_d = (busy_q & ~clrMask) | setMask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastGrant_q     <= 2'd2;
            registerWrite_q <= 2'b00;
            regWriteLocal_q <= '0;
            dataWrite_q     <= '0;
            r0Write_q       <= '0;
            busy_q          <= '0;
        end else begin
            lastGrant_q     <= lastGrant_d;
            registerWrite_q <= registerWrite_d;
            busy_q          <= busy_d;
            if (transfer) begin
                regWriteLocal_q <= selDest;
                dataWrite_q     <= req_data[selIdx*DATA_WIDTH +: DATA_WIDTH];
                r0Write_q       <= req_r0data[selIdx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign registerWrite = registerWrite_q;
    assign regWriteLocal = regWriteLocal_q;
    assign dataWrite     = dataWrite_q;
    assign r0Write       = r0Write_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single and dual writes,
// round-robin order, scoreboard set/clear and reset during a transfer.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_dest_en;
    logic [2:0]  req_r0_en;
    logic [11:0] req_dest;
    logic [47:0] req_data;
    logic [47:0] req_r0data;
    logic        claim_valid;
    logic        claim_dest_en;
    logic [3:0]  claim_dest;
    logic        claim_r0_en;
    logic [1:0]  registerWrite;
    logic [3:0]  regWriteLocal;
    logic [15:0] dataWrite;
    logic [15:0] r0Write;
    logic [15:0] busy;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_en(req_dest_en), .req_r0_en(req_r0_en),
        .req_dest(req_dest), .req_data(req_data), .req_r0data(req_r0data),
        .claim_valid(claim_valid), .claim_dest_en(claim_dest_en),
        .claim_dest(claim_dest), .claim_r0_en(claim_r0_en),
        .registerWrite(registerWrite), .regWriteLocal(regWriteLocal),
        .dataWrite(dataWrite), .r0Write(r0Write), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic dEn, input logic rEn,
                                 input logic [3:0] dest, input logic [15:0] data, input logic [15:0] r0d);
        req_valid[i]          = v;
        req_dest_en[i]        = dEn;
        req_r0_en[i]          = rEn;
        req_dest[i*4 +: 4]    = dest;
        req_data[i*16 +: 16]  = data;
        req_r0data[i*16 +: 16] = r0d;
        #1;
    endtask

    task automatic clearReqs();
        req_valid = '0; req_dest_en = '0; req_r0_en = '0;
        req_dest = '0; req_data = '0; req_r0data = '0;
        #1;
    endtask

    task automatic setClaim(input logic v, input logic dEn, input logic [3:0] dest, input logic rEn);
        claim_valid = v; claim_dest_en = dEn; claim_dest = dest; claim_r0_en = rEn;
        #1;
    endtask

    logic [15:0] rrData [3];
    logic [7:0]  rrCount [3];

    initial begin
        reset = 1'b1;
        clearReqs();
        setClaim(1'b0, 1'b0, 4'd0, 1'b0);

        // Reset held two cycles with every requester valid
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b1, 1'b0, 4'(i + 1), 16'h1111, 16'h2222);
        tick();
        tick();
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_regwrite", 32'(registerWrite), 32'h0);
        checkOutput("reset_local", 32'(regWriteLocal), 32'h0);
        checkOutput("reset_data", 32'(dataWrite), 32'h0);
        checkOutput("reset_r0", 32'(r0Write), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);

        reset = 1'b0;
        clearReqs();
        tick();

        // Single ALU write
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, 16'h0000);
        checkOutput("single_ready", 32'(req_ready), 32'h1);
        tick();
        clearReqs();
        checkOutput("single_regwrite", 32'(registerWrite), 32'h1);
        checkOutput("single_local", 32'(regWriteLocal), 32'h5);
        checkOutput("single_data", 32'(dataWrite), 32'h1234);
        tick();
        checkOutput("idle_regwrite", 32'(registerWrite), 32'h0);
        checkOutput("idle_data_hold", 32'(dataWrite), 32'h1234);

        // Fresh reset so round-robin starts at requester 0
        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            rrCount[i] = 8'd0;
            rrData[i]  = {4'hA, 4'(i), 8'd0};
            applyStimulus(i, 1'b1, 1'b1, 1'b0, 4'(i + 8), rrData[i], 16'h0000);
        end
        for (int k = 0; k < 6; k++) begin
            int g;
            logic [15:0] expData;
            g = k % 3;
            expData = rrData[g];
            checkOutput($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(3'b001 << g));
            tick();
            rrCount[g] = rrCount[g] + 8'd1;
            rrData[g]  = {4'hA, 4'(g), rrCount[g]};
            applyStimulus(g, 1'b1, 1'b1, 1'b0, 4'(g + 8), rrData[g], 16'h0000);
            checkOutput($sformatf("rr_regwrite_%0d", k), 32'(registerWrite), 32'h1);
            checkOutput($sformatf("rr_local_%0d", k), 32'(regWriteLocal), 32'(g + 8));
            checkOutput($sformatf("rr_data_%0d", k), 32'(dataWrite), 32'(expData));
        end
        clearReqs();
        tick();

        // MUL/DIV dual write, then dest R0 collision
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 4'd3, 16'h00FF, 16'hABCD);
        checkOutput("dual_ready", 32'(req_ready), 32'h2);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 4'd0, 16'h5555, 16'h7777);
        checkOutput("dual_regwrite", 32'(registerWrite), 32'h3);
        checkOutput("dual_local", 32'(regWriteLocal), 32'h3);
        checkOutput("dual_data", 32'(dataWrite), 32'h00FF);
        checkOutput("dual_r0", 32'(r0Write), 32'hABCD);
        checkOutput("r0clash_ready", 32'(req_ready), 32'h2);
        tick();
        clearReqs();
        checkOutput("r0clash_regwrite", 32'(registerWrite), 32'h1);
        checkOutput("r0clash_local", 32'(regWriteLocal), 32'h0);
        checkOutput("r0clash_data", 32'(dataWrite), 32'h5555);

        // Request with no enables is consumed and still advances the pointer
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'd6, 16'hDEAD, 16'hBEEF);
        checkOutput("noen_ready", 32'(req_ready), 32'h1);
        tick();
        checkOutput("noen_regwrite", 32'(registerWrite), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b1, 1'b0, 4'd9, 16'h0001, 16'h0000);
        checkOutput("noen_advance_ready", 32'(req_ready), 32'h2);
        clearReqs();
        tick();

        // Scoreboard: claim R7 and R0, then LOAD writes R7
        setClaim(1'b1, 1'b1, 4'd7, 1'b1);
        tick();
        setClaim(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("claim_busy", 32'(busy), 32'h0081);
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 4'd7, 16'h0777, 16'h0000);
        checkOutput("load_ready", 32'(req_ready), 32'h4);
        tick();
        clearReqs();
        checkOutput("load_regwrite", 32'(registerWrite), 32'h1);
        checkOutput("load_busy_pending", 32'(busy), 32'h0081);
        tick();
        checkOutput("load_busy_cleared", 32'(busy), 32'h0001);

        // Claim and clear of R7 in the same cycle: claim wins
        applyStimulus(2, 1'b1, 1'b1, 1'b0, 4'd7, 16'h0778, 16'h0000);
        tick();
        clearReqs();
        setClaim(1'b1, 1'b1, 4'd7, 1'b0);
        tick();
        setClaim(1'b0, 1'b0, 4'd0, 1'b0);
        checkOutput("setwins_busy", 32'(busy), 32'h0081);
        tick();
        checkOutput("setwins_hold", 32'(busy), 32'h0081);

        // Reset arriving in the same cycle as a would-be grant
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h4242, 16'h0000);
        reset = 1'b1;
        #1;
        checkOutput("midreset_ready", 32'(req_ready), 32'h0);
        tick();
        checkOutput("midreset_regwrite", 32'(registerWrite), 32'h0);
        checkOutput("midreset_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        clearReqs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
